// File: rtl/corr_tx_scheduler.sv
// -----------------------------------------------------------------------------
// corr_tx_scheduler
//
// Round-robin scheduler sharing one hex-word UART transmitter between NUM_CH
// correlator result channels. One pending channel is granted at a time. Its
// word is latched and presented to the transmitter. The scheduler then waits
// for a fresh rising edge of tx_done before it arbitrates again. Completed
// words are counted. A word that stalls longer than TIMEOUT cycles is aborted
// and flagged in a sticky error bit.
//
// Optional feature (macro CORR_TX_HEADER_EN):
//   When defined, HEADER_WORD is sent before the first channel word of every
//   sweep. A sweep boundary is the first grant after reset, or any grant where
//   the round-robin pointer wrapped. When undefined, no header is ever sent.
//
// Parameters:
//   RESOLUTION  - word width in bits (multiple of 4)
//   NUM_CH      - number of requesting channels (2..16)
//   TIMEOUT     - cycles allowed per word in HDR/SEND before abort
//   HEADER_WORD - sync word sent per sweep (header build only)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ch_req      in   per-channel request level, held until acked
//   ch_data     in   flattened channel words, channel i at [i*RESOLUTION +: RESOLUTION]
//   ch_ack      out  one-cycle pulse: channel word latched
//   tx_data     out  registered word presented to the transmitter
//   tx_enable   out  registered transmitter enable
//   tx_done     in   transmitter done level, synchronous to clk
//   busy        out  high whenever the scheduler is not idle
//   words_sent  out  completed words (headers included), wraps at 16 bits
//   timeout_err out  sticky abort flag, cleared only by reset
// -----------------------------------------------------------------------------
module corr_tx_scheduler #(
   parameter int unsigned              RESOLUTION  = 32,
   parameter int unsigned              NUM_CH      = 4,
   parameter logic [23:0]              TIMEOUT     = 24'd5000000,
   parameter logic [RESOLUTION-1:0]    HEADER_WORD = 32'hFFFFFFFF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            ch_req,
   input  logic [NUM_CH*RESOLUTION-1:0] ch_data,
   output logic [NUM_CH-1:0]            ch_ack,
   output logic [RESOLUTION-1:0]        tx_data,
   output logic                         tx_enable,
   input  logic                         tx_done,
   output logic                         busy,
   output logic [15:0]                  words_sent,
   output logic                         timeout_err
);

   localparam int unsigned         GW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [GW-1:0]       LAST_CH = GW'(NUM_CH - 1);
   localparam logic [NUM_CH-1:0]   ACK_CH0 = NUM_CH'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
`ifdef CORR_TX_HEADER_EN
   localparam logic [1:0] ST_HDR  = 2'd3;
`endif

   // State registers
   logic [1:0]            r_state;
   logic [GW-1:0]         r_grant;
   logic [GW-1:0]         r_last_grant;
   logic                  r_done_q;
   logic [23:0]           r_timer;
   logic [RESOLUTION-1:0] r_tx_data;
   logic                  r_tx_enable;
   logic [NUM_CH-1:0]     r_ch_ack;
   logic [15:0]           r_words_sent;
   logic                  r_timeout_err;
`ifdef CORR_TX_HEADER_EN
   logic                  r_sweep_start;
   logic                  w_sweep_nxt;
   logic                  w_sweep;
`else
   logic                  w_unused_hdr;
   assign w_unused_hdr = ^HEADER_WORD;
`endif

   // Next-state wires
   logic [1:0]            w_state_nxt;
   logic [GW-1:0]         w_grant_nxt;
   logic [GW-1:0]         w_last_grant_nxt;
   logic [23:0]           w_timer_nxt;
   logic [RESOLUTION-1:0] w_tx_data_nxt;
   logic                  w_tx_enable_nxt;
   logic [NUM_CH-1:0]     w_ch_ack_nxt;
   logic [15:0]           w_words_sent_nxt;
   logic                  w_timeout_err_nxt;

   logic                  w_req_any;
   logic [GW-1:0]         w_req_idx;
   logic                  w_done_edge;
   logic                  w_timer_hit;

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      logic [GW-1:0] idx;
      int unsigned   sum;
      w_req_any = 1'b0;
      w_req_idx = r_last_grant;
      idx       = '0;
      sum       = 0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         sum = 32'(r_last_grant) + k;
         if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
         end
         idx = GW'(sum);
         if (!w_req_any && ch_req[idx]) begin
            w_req_any = 1'b1;
            w_req_idx = idx;
         end
      end
   end

   // Only a fresh 0->1 transition completes a word; a level left high from
   // the previous word must not be mistaken for completion.
   assign w_done_edge = tx_done & ~r_done_q;
   assign w_timer_hit = (r_timer == (TIMEOUT - 24'd1));

`ifdef CORR_TX_HEADER_EN
   assign w_sweep = r_sweep_start | (w_req_idx <= r_last_grant);
`endif

   always_comb begin
      w_state_nxt       = r_state;
      w_grant_nxt       = r_grant;
      w_last_grant_nxt  = r_last_grant;
      w_timer_nxt       = r_timer;
      w_tx_data_nxt     = r_tx_data;
      w_tx_enable_nxt   = r_tx_enable;
      w_ch_ack_nxt      = '0;
      w_words_sent_nxt  = r_words_sent;
      w_timeout_err_nxt = r_timeout_err;
`ifdef CORR_TX_HEADER_EN
      w_sweep_nxt       = r_sweep_start;
`endif

      unique case (r_state)
         ST_IDLE: begin
            w_tx_enable_nxt = 1'b0;
            if (w_req_any) begin
               w_grant_nxt      = w_req_idx;
               w_last_grant_nxt = w_req_idx;
               w_timer_nxt      = '0;
`ifdef CORR_TX_HEADER_EN
               w_sweep_nxt      = 1'b0;
               w_state_nxt      = w_sweep ? ST_HDR : ST_LOAD;
`else
               w_state_nxt      = ST_LOAD;
`endif
            end
         end

`ifdef CORR_TX_HEADER_EN
         ST_HDR: begin
            if (w_done_edge) begin
               w_tx_enable_nxt  = 1'b0;
               w_words_sent_nxt = r_words_sent + 16'd1;
               w_state_nxt      = ST_LOAD;
            end else if (w_timer_hit) begin
               // Granted channel was never acked; it keeps requesting.
               w_tx_enable_nxt   = 1'b0;
               w_timeout_err_nxt = 1'b1;
               w_state_nxt       = ST_IDLE;
            end else begin
               w_tx_data_nxt   = HEADER_WORD;
               w_tx_enable_nxt = 1'b1;
               w_timer_nxt     = r_timer + 24'd1;
            end
         end
`endif

         ST_LOAD: begin
            w_tx_data_nxt   = ch_data[32'(r_grant) * RESOLUTION +: RESOLUTION];
            w_ch_ack_nxt    = ACK_CH0 << r_grant;
            w_tx_enable_nxt = 1'b1;
            w_timer_nxt     = '0;
            w_state_nxt     = ST_SEND;
         end

         ST_SEND: begin
            // Done edge takes priority over a simultaneous timeout.
            if (w_done_edge) begin
               w_tx_enable_nxt  = 1'b0;
               w_words_sent_nxt = r_words_sent + 16'd1;
               w_state_nxt      = ST_IDLE;
            end else if (w_timer_hit) begin
               // Word already acked upstream: it is dropped, not re-sent.
               w_tx_enable_nxt   = 1'b0;
               w_timeout_err_nxt = 1'b1;
               w_state_nxt       = ST_IDLE;
            end else begin
               w_timer_nxt = r_timer + 24'd1;
            end
         end

         default: begin
            w_tx_enable_nxt = 1'b0;
            w_state_nxt     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_grant       <= '0;
         r_last_grant  <= LAST_CH;
         r_done_q      <= 1'b0;
         r_timer       <= '0;
         r_tx_data     <= '0;
         r_tx_enable   <= 1'b0;
         r_ch_ack      <= '0;
         r_words_sent  <= '0;
         r_timeout_err <= 1'b0;
`ifdef CORR_TX_HEADER_EN
         r_sweep_start <= 1'b1;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_grant       <= w_grant_nxt;
         r_last_grant  <= w_last_grant_nxt;
         r_done_q      <= tx_done;
         r_timer       <= w_timer_nxt;
         r_tx_data     <= w_tx_data_nxt;
         r_tx_enable   <= w_tx_enable_nxt;
         r_ch_ack      <= w_ch_ack_nxt;
         r_words_sent  <= w_words_sent_nxt;
         r_timeout_err <= w_timeout_err_nxt;
`ifdef CORR_TX_HEADER_EN
         r_sweep_start <= w_sweep_nxt;
`endif
      end
   end

   assign ch_ack      = r_ch_ack;
   assign tx_data     = r_tx_data;
   assign tx_enable   = r_tx_enable;
   assign busy        = (r_state != ST_IDLE);
   assign words_sent  = r_words_sent;
   assign timeout_err = r_timeout_err;

endmodule
